// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared word width and sequencer state encodings for the Hack data memory
// Purpose: the state encoding and default word width used by every Hack memory block.
// Contents: HACK_WORD_W, hack_mem_state_e (ST_IDLE, ST_CLEAR).
package hack_mem_pkg;

    localparam int HACK_WORD_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } hack_mem_state_e;

endpackage

// File: rtl/hack_ram_banked_if.sv
// rtl/hack_ram_banked_if.sv - data/address bus of the banked Hack RAM
// Purpose: groups the user-facing memory bus so it can be passed as one port.
// Signals:
//   in      write data (master -> slave)
//   load    write enable for the word at address (master -> slave)
//   address word address (master -> slave)
//   out     combinational read data, forced to 0 while busy (slave -> master)
//   busy    clear sweep in progress, writes dropped (slave -> master)
interface hack_ram_banked_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
);
    logic [WIDTH-1:0]  in;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out;
    logic              busy;

    modport master (
        output in,
        output load,
        output address,
        input  out,
        input  busy
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        output out,
        output busy
    );
endinterface

// File: rtl/hack_ram_bank.sv
// rtl/hack_ram_bank.sv - one storage bank: clocked write port, combinational read port
// Purpose: 2**BANK_ADDR_W words of WIDTH bits with no reset of their own; contents are
//          undefined until written.
// Ports:
//   clk    clock, writes on posedge
//   we     write enable
//   waddr  write word address
//   wdata  write data
//   raddr  read word address
//   rdata  read data (combinational, shows the old word until the write edge)
module hack_ram_bank #(
    parameter int WIDTH       = 16,
    parameter int BANK_ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [BANK_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [BANK_ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]       rdata
);

    localparam int DEPTH = 2 ** BANK_ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hack_ram_banked.sv
// rtl/hack_ram_banked.sv - banked Hack data memory with reset-triggered clear sweep
// Purpose: 2**ADDR_W words of WIDTH bits built from 2**(ADDR_W-BANK_ADDR_W) banks.
//          Combinational read, clocked write. With CLEAR_ON_RESET set, reset starts a
//          sweep that zeroes one word per cycle; busy is high for its duration, user
//          writes are dropped and out reads 0.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    hack_ram_banked_if.slave: in, load, address -> out, busy
module hack_ram_banked
    import hack_mem_pkg::*;
#(
    parameter int WIDTH          = HACK_WORD_W,
    parameter int ADDR_W         = 6,
    parameter int BANK_ADDR_W    = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    hack_ram_banked_if.slave bus
);

    // A bank wider than the whole memory has no meaning; refuse to elaborate.
    if (ADDR_W < BANK_ADDR_W) begin : g_bad_addr_w
        $fatal(1, "hack_ram_banked: ADDR_W (%0d) < BANK_ADDR_W (%0d)", ADDR_W, BANK_ADDR_W);
    end
    if (BANK_ADDR_W < 1) begin : g_bad_bank_addr_w
        $fatal(1, "hack_ram_banked: BANK_ADDR_W must be at least 1");
    end

    localparam int NBANKS = 2 ** (ADDR_W - BANK_ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    hack_mem_state_e   state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy;

    // ---------------- sweep sequencer ----------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            // Last word is written on this edge; pointer is held rather than wrapped.
            if (clr_ptr_q == LAST_PTR) begin
                state_d = ST_IDLE;
            end else begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // busy decodes a single state flop, so it has no path from the inputs.
    assign busy = (state_q == ST_CLEAR);

    // ---------------- write mux ----------------
    // While reset is held in a clearing build, word 0 keeps being zeroed so the
    // sweep effectively starts during the reset cycle itself.
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] wr_bank;

    assign clr_we   = (reset && CLEAR_ON_RESET) || busy;
    assign clr_addr = reset ? '0 : clr_ptr_q;
    // User writes are dropped while clearing and in any reset cycle.
    assign user_we  = bus.load && !busy && !reset;

    assign wr_en    = clr_we || user_we;
    assign wr_addr  = clr_we ? clr_addr : bus.address;
    assign wr_data  = clr_we ? '0 : bus.in;
    assign wr_bank  = wr_addr >> BANK_ADDR_W;

    // ---------------- banks ----------------
    logic [WIDTH-1:0] bank_rdata [NBANKS];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic bank_we;
        assign bank_we = wr_en && (wr_bank == ADDR_W'(b));

        hack_ram_bank #(
            .WIDTH       (WIDTH),
            .BANK_ADDR_W (BANK_ADDR_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (wr_addr[BANK_ADDR_W-1:0]),
            .wdata (wr_data),
            .raddr (bus.address[BANK_ADDR_W-1:0]),
            .rdata (bank_rdata[b])
        );
    end

    // ---------------- read mux ----------------
    logic [ADDR_W-1:0] rd_bank;
    logic [WIDTH-1:0]  rd_word;

    assign rd_bank = bus.address >> BANK_ADDR_W;

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NBANKS; b++) begin
            if (rd_bank == ADDR_W'(b)) begin
                rd_word = bank_rdata[b];
            end
        end
    end

    assign bus.out  = busy ? '0 : rd_word;
    assign bus.busy = busy;

endmodule

// File: tb/tb_hack_ram_banked.sv
// tb/tb_hack_ram_banked.sv - self-checking bench for hack_ram_banked (clearing and non-clearing builds)
module tb_hack_ram_banked;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    hack_ram_banked_if #(.WIDTH(16), .ADDR_W(6)) a_if ();
    hack_ram_banked_if #(.WIDTH(16), .ADDR_W(9)) b_if ();

    hack_ram_banked #(
        .WIDTH(16), .ADDR_W(6), .BANK_ADDR_W(3), .CLEAR_ON_RESET(1'b1)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if)
    );

    hack_ram_banked #(
        .WIDTH(16), .ADDR_W(9), .BANK_ADDR_W(6), .CLEAR_ON_RESET(1'b0)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_a [64];
    logic [15:0] model_b [512];
    bit          known_b [512];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input int addr, input logic [15:0] data);
        a_if.address = 6'(addr);
        a_if.in      = data;
        a_if.load    = 1'b1;
        tick();
        a_if.load    = 1'b0;
        model_a[addr] = data;
    endtask

    task automatic a_read(input string tag, input int addr);
        a_if.address = 6'(addr);
        #1;
        check_eq(tag, {16'h0, a_if.out}, {16'h0, model_a[addr]});
    endtask

    // Waits for the sweep to end; out must read 0 throughout. Optionally tries a
    // write mid-sweep, which must be dropped.
    task automatic a_wait_sweep(input bit poke, output int n);
        n = 0;
        while (a_if.busy === 1'b1 && n < 300) begin
            if (poke && n == 3) begin
                a_if.address = 6'd3;
                a_if.in      = 16'hFFFF;
                a_if.load    = 1'b1;
            end else begin
                a_if.load    = 1'b0;
            end
            if (n % 16 == 5) begin
                #1;
                check_eq("out_zero_while_busy", {16'h0, a_if.out}, 32'h0);
            end
            tick();
            n++;
        end
        a_if.load = 1'b0;
        // The sweep zeroes everything regardless of earlier contents.
        for (int i = 0; i < 64; i++) model_a[i] = 16'h0;
    endtask

    initial begin
        int n;
        int hi;
        int addr;
        logic [15:0] data;
        bit ld;

        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.load = 1'b0; a_if.in = '0; a_if.address = '0;
        b_if.load = 1'b0; b_if.in = '0; b_if.address = '0;
        for (int i = 0; i < 512; i++) known_b[i] = 1'b0;

        // ---- T1 / T4: reset sweep, with a dropped write during it ----
        tick();
        check_eq("reset_busy_a", {31'h0, a_if.busy}, 32'd1);
        check_eq("reset_busy_b", {31'h0, b_if.busy}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        a_wait_sweep(1'b1, n);
        check_eq("sweep_len", n, 32'd64);
        for (int i = 0; i < 64; i++) a_read("after_sweep_zero", i);

        // ---- T2: writes across banks, no aliasing ----
        a_write(7, 16'hBEEF);
        a_write(8, 16'h1234);
        a_read("rd_7", 7);
        a_read("rd_8", 8);
        a_read("rd_9_zero", 9);
        check_eq("rd_9_const", {16'h0, a_if.out}, 32'h0);

        // ---- T3: read-during-write ----
        a_write(5, 16'h00AA);
        a_if.address = 6'd5;
        a_if.in      = 16'h5500;
        a_if.load    = 1'b1;
        #1;
        check_eq("rdw_before_edge", {16'h0, a_if.out}, 32'h00AA);
        tick();
        a_if.load = 1'b0;
        check_eq("rdw_after_edge", {16'h0, a_if.out}, 32'h5500);
        model_a[5] = 16'h5500;

        // ---- randomized traffic against the array model ----
        for (int k = 0; k < 300; k++) begin
            addr = int'($urandom_range(63));
            data = 16'($urandom);
            ld   = ($urandom_range(2) != 0);
            a_if.address = 6'(addr);
            a_if.in      = data;
            a_if.load    = ld;
            #1;
            check_eq("rand_read", {16'h0, a_if.out}, {16'h0, model_a[addr]});
            tick();
            if (ld) model_a[addr] = data;
        end
        a_if.load = 1'b0;
        for (int i = 0; i < 64; i += 7) a_read("rand_final", i);

        // ---- T5: reset mid-sweep over pre-filled memory ----
        for (int i = 0; i < 64; i++) a_write(i, 16'h5A5A);
        a_read("prefill_63", 63);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        repeat (20) tick();
        check_eq("mid_sweep_busy", {31'h0, a_if.busy}, 32'd1);
        rst_a = 1'b1;
        tick();
        check_eq("restart_busy", {31'h0, a_if.busy}, 32'd1);
        rst_a = 1'b0;
        a_wait_sweep(1'b0, n);
        check_eq("restart_sweep_len", n, 32'd64);
        for (int i = 0; i < 64; i++) a_read("restart_zero", i);

        // ---- T6: non-clearing build keeps contents across reset ----
        b_if.address = 9'd300;
        b_if.in      = 16'hCAFE;
        b_if.load    = 1'b1;
        tick();
        b_if.load    = 1'b0;
        model_b[300] = 16'hCAFE;
        known_b[300] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            addr = int'($urandom_range(511));
            if (addr == 300) addr = 301;
            data = 16'($urandom);
            b_if.address = 9'(addr);
            b_if.in      = data;
            b_if.load    = 1'b1;
            tick();
            model_b[addr] = data;
            known_b[addr] = 1'b1;
        end
        b_if.load = 1'b0;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        hi = 0;
        for (int k = 0; k < 70; k++) begin
            if (b_if.busy !== 1'b0) hi++;
            tick();
        end
        check_eq("b_busy_never", hi, 32'd0);
        b_if.address = 9'd300;
        #1;
        check_eq("b_cafe_kept", {16'h0, b_if.out}, 32'hCAFE);
        for (int i = 0; i < 512; i++) begin
            if (known_b[i]) begin
                b_if.address = 9'(i);
                #1;
                check_eq("b_kept", {16'h0, b_if.out}, {16'h0, model_b[i]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
